pe_input_buffer: RTL and testbench

Upstream feeder for `pe_controller`: accepts a valid/ready word stream, fills a local buffer of 2^(L_RAM_SIZE+1) 32-bit words in address order, then pulses `start` and serves `pe_controller`'s read port (`rdaddr` → `rddata`, one-cycle latency) until `done`. The buffer then re-arms for the next frame. This replaces the preloaded `din.mem` image with a live producer and gives the PE a fixed frame boundary.

---
 rtl/pe_input_buffer.sv | 157 +++++++++++++++
 tb/tb_pe_input_buffer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pe_input_buffer.sv
// pe_input_buffer: stream-fed operand buffer for pe_controller.
// Fills N = 2^(L_RAM_SIZE+1) words in address order, pulses start, then serves
// the PE read port until done, and re-arms for the next frame.
// Optional feature macro: PE_INBUF_PAD_EN (zero-pad a short frame up to N-1).
//
// state   | meaning
// --------+--------------------------------------------------------------
// FILL    | accepting stream words at wr_ptr; s_tready high
// ARM     | buffer full; one-cycle start pulse to pe_controller
// WAIT    | PE owns the buffer; leave on done
// PAD     | (PE_INBUF_PAD_EN only) writing zeros after an early s_tlast

module pe_input_buffer #(
    parameter int L_RAM_SIZE = 4,
    parameter int DATA_W     = 32
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic [DATA_W-1:0]     s_tdata,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    input  logic                  s_tlast,
    output logic                  start,
    input  logic                  done,
    input  logic [L_RAM_SIZE:0]   rdaddr,
    output logic [DATA_W-1:0]     rddata,
    output logic                  busy,
    output logic                  err_len
);

    localparam int AW = L_RAM_SIZE + 1;
    localparam int N  = 1 << AW;
    localparam logic [AW-1:0] LAST_ADDR = '1;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_ARM  = 2'd1,
`ifdef PE_INBUF_PAD_EN
        ST_WAIT = 2'd2,
        ST_PAD  = 2'd3
`else
        ST_WAIT = 2'd2
`endif
    } state_t;

    state_t              state_q, state_d;
    logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
    logic                err_len_q, err_len_d;
    logic                s_tready_q;
    logic                start_q;
    logic                busy_q;
    logic [DATA_W-1:0]   rddata_q;

    logic                accept;
    logic                mem_we;
    logic [DATA_W-1:0]   mem_wdata;

    logic [DATA_W-1:0]   mem [N];

    // s_tready is registered so it stays low through reset; it always mirrors state_q == FILL.
    assign accept = s_tvalid && s_tready_q;

    // Next-state, write pointer, memory write and length-error logic.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        err_len_d = err_len_q;
        mem_we    = 1'b0;
        mem_wdata = '0;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    mem_we    = 1'b1;
                    mem_wdata = s_tdata;
                    wr_ptr_d  = wr_ptr_q + 1'b1;
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d = ST_ARM;
                        if (!s_tlast) begin
                            err_len_d = 1'b1;
                        end
                    end else if (s_tlast) begin
                        err_len_d = 1'b1;
`ifdef PE_INBUF_PAD_EN
                        state_d = ST_PAD;
`endif
                    end
                end
            end
            ST_ARM: begin
                // done is deliberately not looked at here; WAIT must see it.
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (done) begin
                    state_d  = ST_FILL;
                    wr_ptr_d = '0;
                end
            end
`ifdef PE_INBUF_PAD_EN
            ST_PAD: begin
                mem_we    = 1'b1;
                mem_wdata = '0;
                wr_ptr_d  = wr_ptr_q + 1'b1;
                if (wr_ptr_q == LAST_ADDR) begin
                    state_d = ST_ARM;
                end
            end
`endif
            default: begin
                state_d  = ST_FILL;
                wr_ptr_d = '0;
            end
        endcase
    end

    // State, pointer and registered status outputs.
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q    <= ST_FILL;
            wr_ptr_q   <= '0;
            err_len_q  <= 1'b0;
            s_tready_q <= 1'b0;
            start_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            err_len_q  <= err_len_d;
            s_tready_q <= (state_d == ST_FILL);
            start_q    <= (state_d == ST_ARM);
            busy_q     <= (state_d != ST_FILL);
        end
    end

    // Buffer write port; contents survive reset, writes are blocked while it is held.
    always_ff @(posedge aclk) begin
        if (mem_we && !areset) begin
            mem[wr_ptr_q] <= mem_wdata;
        end
    end

    // Free-running synchronous read port; read-during-write returns the old word.
    always_ff @(posedge aclk) begin
        if (areset) begin
            rddata_q <= '0;
        end else begin
            rddata_q <= mem[rdaddr];
        end
    end

    assign s_tready = s_tready_q;
    assign start    = start_q;
    assign busy     = busy_q;
    assign err_len  = err_len_q;
    assign rddata   = rddata_q;

endmodule

// File: tb/tb_pe_input_buffer.sv
// Self-checking bench for pe_input_buffer (L_RAM_SIZE=4, N=32).
`timescale 1ns/1ps

module tb_pe_input_buffer;

    localparam int L  = 4;
    localparam int N  = 1 << (L + 1);
    localparam int DW = 32;

    logic          aclk = 1'b0;
    logic          areset;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic          start;
    logic          done;
    logic [L:0]    rdaddr;
    logic [DW-1:0] rddata;
    logic          busy;
    logic          err_len;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] fr_data   [N];
    logic          fr_last   [N];
    logic [DW-1:0] mem_model [N];
    logic          err_model;

    pe_input_buffer #(.L_RAM_SIZE(L), .DATA_W(DW)) dut (
        .aclk     (aclk),
        .areset   (areset),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .start    (start),
        .done     (done),
        .rdaddr   (rdaddr),
        .rddata   (rddata),
        .busy     (busy),
        .err_len  (err_len)
    );

    always #5 aclk = ~aclk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    // Push one frame (n_words accepts), then check the start pulse and the ARM->WAIT step.
    task automatic send_frame(input int n_words, input bit bursty, input bit spur_done);
        int idx;
        int cyc;
        idx = 0;
        cyc = 0;
        while (idx < n_words && cyc < 2000) begin
            s_tvalid = bursty ? ($urandom_range(0, 1) == 1) : 1'b1;
            s_tdata  = fr_data[idx];
            s_tlast  = fr_last[idx];
            if (spur_done) done = ($urandom_range(0, 3) == 0);
            checks++;
            if (s_tready !== 1'b1 || start !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL fill_status word %0d: ready=%b start=%b busy=%b, want 1 0 0",
                         idx, s_tready, start, busy);
            end
            tick();
            if (s_tvalid) idx++;
            cyc++;
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        done     = 1'b0;
        checks++;
        if (idx != n_words) begin
            errors++;
            $display("FAIL fill_budget: accepted %0d words, want %0d", idx, n_words);
        end
        if (!bursty) begin
            checks++;
            if (cyc != n_words) begin
                errors++;
                $display("FAIL fill_cycles: %0d cycles, want %0d", cyc, n_words);
            end
        end

        for (int i = 0; i < N; i++) mem_model[i] = (i < n_words) ? fr_data[i] : '0;
        for (int i = 0; i < n_words; i++) if (fr_last[i] && i != N - 1) err_model = 1'b1;
        if (n_words == N && !fr_last[N-1]) err_model = 1'b1;

        for (int c = 0; c < N - n_words; c++) begin
            checks++;
            if (start !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pad_status cycle %0d: start=%b ready=%b busy=%b, want 0 0 1",
                         c, start, s_tready, busy);
            end
            tick();
        end
        checks++;
        if (start !== 1'b1 || s_tready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL start_pulse: start=%b ready=%b busy=%b, want 1 0 1", start, s_tready, busy);
        end
        if (spur_done) done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (start !== 1'b0 || s_tready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL arm_to_wait: start=%b ready=%b busy=%b, want 0 0 1", start, s_tready, busy);
        end
        checks++;
        if (err_len !== err_model) begin
            errors++;
            $display("FAIL err_len_frame: got %b want %b", err_len, err_model);
        end
    endtask

    task automatic read_all();
        for (int a = 0; a < N; a++) begin
            rdaddr = a[L:0];
            tick();
            checks++;
            if (rddata !== mem_model[a]) begin
                errors++;
                $display("FAIL readback addr %0d: got %h want %h", a, rddata, mem_model[a]);
            end
        end
    endtask

    task automatic send_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b0 || start !== 1'b0) begin
            errors++;
            $display("FAIL done_release: ready=%b busy=%b start=%b, want 1 0 0", s_tready, busy, start);
        end
    endtask

    task automatic fill_seq_frame();
        for (int i = 0; i < N; i++) begin
            fr_data[i] = 32'h3F80_0000 + i;
            fr_last[i] = (i == N - 1);
        end
    endtask

    task automatic fill_rand_frame();
        for (int i = 0; i < N; i++) begin
            fr_data[i] = $urandom;
            fr_last[i] = (i == N - 1);
        end
    endtask

    task automatic test_reset();
        areset = 1'b1;
        tick();
        tick();
        checks++;
        if (s_tready !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0 || rddata !== '0) begin
            errors++;
            $display("FAIL reset_values: ready=%b start=%b busy=%b err=%b rddata=%h, want all 0",
                     s_tready, start, busy, err_len, rddata);
        end
        areset = 1'b0;
        tick();
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release: ready=%b busy=%b, want 1 0", s_tready, busy);
        end
        err_model = 1'b0;
    endtask

    task automatic test_basic();
        fill_seq_frame();
        send_frame(N, 1'b0, 1'b0);
        read_all();
        send_done();
    endtask

    task automatic test_backpressure();
        fill_rand_frame();
        send_frame(N, 1'b0, 1'b0);
        for (int c = 0; c < 100; c++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tlast  = $urandom_range(0, 1);
            checks++;
            if (s_tready !== 1'b0 || start !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: ready=%b start=%b, want 0 0", c, s_tready, start);
            end
            tick();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        read_all();
        send_done();
    endtask

    task automatic test_bursty();
        void'($urandom(1));
        fill_seq_frame();
        send_frame(N, 1'b1, 1'b0);
        read_all();
        send_done();
    endtask

    task automatic test_spurious_done();
        done = 1'b1;
        tick();
        done = 1'b0;
        checks++;
        if (s_tready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL spurious_fill: ready=%b busy=%b, want 1 0", s_tready, busy);
        end
        fill_rand_frame();
        send_frame(N, 1'b0, 1'b1);
        for (int c = 0; c < 5; c++) begin
            tick();
            checks++;
            if (s_tready !== 1'b0 || busy !== 1'b1 || start !== 1'b0) begin
                errors++;
                $display("FAIL spurious_hold cycle %0d: ready=%b busy=%b start=%b, want 0 1 0",
                         c, s_tready, busy, start);
            end
        end
        read_all();
        send_done();
    endtask

    task automatic test_early_last();
        fill_rand_frame();
        fr_last[9] = 1'b1;
`ifdef PE_INBUF_PAD_EN
        send_frame(10, 1'b0, 1'b0);
`else
        send_frame(N, 1'b0, 1'b0);
`endif
        read_all();
        send_done();
        checks++;
        if (err_len !== 1'b1) begin
            errors++;
            $display("FAIL err_len_sticky: got %b want 1", err_len);
        end
    endtask

    task automatic test_reset_mid_fill();
        for (int i = 0; i < 13; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = $urandom;
            s_tlast  = 1'b0;
            tick();
        end
        s_tvalid = 1'b0;
        areset   = 1'b1;
        tick();
        checks++;
        if (s_tready !== 1'b0 || start !== 1'b0 || busy !== 1'b0 || err_len !== 1'b0 || rddata !== '0) begin
            errors++;
            $display("FAIL midfill_reset: ready=%b start=%b busy=%b err=%b rddata=%h, want all 0",
                     s_tready, start, busy, err_len, rddata);
        end
        err_model = 1'b0;
        areset = 1'b0;
        tick();
        checks++;
        if (s_tready !== 1'b1) begin
            errors++;
            $display("FAIL midfill_release: ready=%b want 1", s_tready);
        end
        fill_rand_frame();
        send_frame(N, 1'b0, 1'b0);
        read_all();
        send_done();
    endtask

    initial begin
        areset   = 1'b1;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        done     = 1'b0;
        rdaddr   = '0;
        err_model = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_bursty();
        test_spurious_done();
        test_early_last();
        test_reset_mid_fill();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
